ec_point_add_double: RTL and testbench
======================================

Name: ec_point_add_double

Overview:
- Sequential affine point adder/doubler for secp256k1: y^2 = x^3 + 7 over GF(p), p = 2^256 - 2^32 - 977.
- One block serves both addition (R = P + Q) and doubling (R = 2P), selected by an input.
- It is the arithmetic engine under the scalar-multiplication controller, which pulses Reset to start an operation and polls Done.

Parameters:
- FIELD_W, 256, coordinate width in bits. Fixed; the only supported value.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high; acts as both reset and start.
- P  input  curve_point_t (x, y; 256 bits each)  first operand.
- Q  input  curve_point_t  second operand; ignored when dbl = 1.
- dbl  input  1  1 = compute 2P; 0 = compute P + Q.
- R  output  curve_point_t  result.
- Done  output  1  high while R is valid.

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock clk.
- Operand capture:
  - Every cycle with Reset = 1, P, Q and dbl are latched into internal registers.
  - The same cycles clear Done to 0, R to (0,0), and the FSM to IDLE-load.
  - Inputs are ignored after Reset deasserts; the first Reset-low cycle starts computation.
- Formulas, all mod p, operands assumed < p:
  - Add: lam = (Qy - Py) * (Qx - Px)^-1.
  - Double: lam = 3*Px^2 * (2*Py)^-1.
  - Both: x3 = lam^2 - Px - Qx (Qx := Px when doubling); y3 = lam*(Px - x3) - Py.
- FSM states: LOAD, NUM, DEN, INV, LAM, X3, Y3, DONE.
  - Each multiplying state issues one or more field_mul transactions.
  - Add/sub/double steps are single-cycle: compute a + b or a - b, then correct by ±p once.
  - INV uses Fermat: den^(p-2) by MSB-first square-and-multiply, reusing field_mul.
- Latency: from first Reset-low cycle to Done = 1, at most 140,000 cycles, identical for add and double.
- Completion: on entering DONE, R <= (x3, y3) and Done <= 1 in the same cycle. Both hold until the next Reset.
- Reset mid-operation: aborts immediately. New operands are captured and the run restarts; no partial result appears on R.
- Denominator zero:
  - Cases: add with Px == Qx, or double with Py == 0.
  - Without the optional feature, R is unspecified but Done still asserts within the latency bound.
  - Inverse of 0 is computed as 0.

Optional Feature:
- Macro: EC_SPECIAL_CASE_EN.
- When defined, (0,0) encodes the point at infinity O, and these cases are checked in the LOAD cycle:
  - P == O: R = Q (add) or O (double).
  - Q == O on add: R = P.
  - Add with P == Q: the unit performs doubling.
  - Add with Px == Qx and Py != Qy: R = O.
  - Double with Py == 0: R = O.
- Special-case results assert Done within 4 cycles.
- When undefined, none of these checks exist and the zero-denominator behaviour above applies.

Decomposition:
- Package ec_pkg holds:
  - typedef curve_point_t (struct packed {logic [255:0] x, y;});
  - constant P_MOD;
  - constant P_MINUS_2;
  - constants GX, GY for tests.
- One sub-module, field_mul:
  - Ports: clk, start, a, b, out, done.
  - Bit-serial MSB-first interleaved multiply: per bit, acc = 2*acc (+ b), with up to two conditional subtractions of p.
  - 257 cycles per product; done pulses for one cycle.

Test Plan:
- Double G:
  - Stimulus: dbl = 1, P = G (x = 79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, y = 483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8), Reset high 1 cycle.
  - Response: Done within 140,000 cycles; R = 2G (x = C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, y = 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A).
- Add:
  - Stimulus: dbl = 0, P = 2G, Q = G.
  - Response: R = 3G (x = F9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9, y = 388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672).
- Commutativity: P = G, Q = 2G gives the same 3G value; Done and R stay stable for 100 cycles after completion.
- Reset mid-run:
  - Stimulus: start a double of G, assert Reset at cycle 1000 with dbl = 0, P = 2G, Q = G.
  - Response: Done stays 0 until the new run completes; R = 3G.
- Reset values: Reset held 5 cycles gives R = (0,0) and Done = 0 on every one of those cycles.
- With EC_SPECIAL_CASE_EN:
  - P = (0,0), Q = G, dbl = 0: R = G within 4 cycles.
  - P = G, Q = G, dbl = 0: R = 2G.
  - P = G, Q = (Gx, p - Gy): R = (0,0).

Source files
------------

// File: rtl/ec_pkg.sv
// Shared types, curve constants and single-step modular helpers for the secp256k1 point unit.
package ec_pkg;

  localparam int EC_W = 256;

  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
  } curve_point_t;

  localparam logic [255:0] P_MOD     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] P_MINUS_2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;
  localparam logic [255:0] GX        = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY        = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_NUM  = 3'd1;
  localparam logic [2:0] S_DEN  = 3'd2;
  localparam logic [2:0] S_INV  = 3'd3;
  localparam logic [2:0] S_LAM  = 3'd4;
  localparam logic [2:0] S_X3   = 3'd5;
  localparam logic [2:0] S_Y3   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  function automatic logic [255:0] mod_add(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    else s = s;
    return s[255:0];
  endfunction

  // A borrow wraps modulo 2^257; adding p lands back in [0, p) in the low bits.
  function automatic logic [255:0] mod_sub(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[256]) d = d + {1'b0, P_MOD};
    else d = d;
    return d[255:0];
  endfunction

  function automatic logic [255:0] mul_step(input logic [255:0] acc, input logic [255:0] b,
                                            input logic sel);
    logic [257:0] t;
    t = {1'b0, acc, 1'b0} + (sel ? {2'b00, b} : 258'd0);
    if (t >= {2'b00, P_MOD}) t = t - {2'b00, P_MOD};
    else t = t;
    if (t >= {2'b00, P_MOD}) t = t - {2'b00, P_MOD};
    else t = t;
    return t[255:0];
  endfunction

endpackage

// File: rtl/ec_point_add_double_field_mul.sv
// Bit-serial MSB-first interleaved modular multiplier; a start pulse always restarts it.
module field_mul
  import ec_pkg::*;
(
  input  logic         clk,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] out,
  output logic         done
);

  logic [255:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [8:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d, done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = 256'd0;
      cnt_d  = 9'd256;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = mul_step(acc_q, b_q, a_q[255]);
      a_d    = {a_q[254:0], 1'b0};
      cnt_d  = cnt_q - 9'd1;
      busy_d = (cnt_q != 9'd1);
      done_d = (cnt_q == 9'd1);
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    acc_q  <= acc_d;
    cnt_q  <= cnt_d;
    busy_q <= busy_d;
    done_q <= done_d;
  end

  assign out  = acc_q;
  assign done = done_q;

endmodule

// File: rtl/ec_point_add_double.sv
// Affine secp256k1 point add / double engine; Reset both clears and starts a run.
// Optional macro EC_SPECIAL_CASE_EN enables point-at-infinity handling in LOAD.
module ec_point_add_double
  import ec_pkg::*;
#(
  parameter int FIELD_W = 256
) (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t P,
  input  curve_point_t Q,
  input  logic         dbl,
  output curve_point_t R,
  output logic         Done
);

  logic [2:0]         state_q, state_d;
  logic [FIELD_W-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  logic [FIELD_W-1:0] num_q, num_d, den_q, den_d, inv_q, inv_d, lam_q, lam_d, x3_q, x3_d;
  logic [FIELD_W-1:0] ma_q, ma_d, mb_q, mb_d, mul_out;
  logic [7:0]         idx_q, idx_d;
  logic               dbl_q, dbl_d, wait_q, wait_d, mstart_q, mstart_d;
  logic               mphase_q, mphase_d, done_q, done_d, mul_done, mul_ack;
  curve_point_t       r_q, r_d;

  field_mul u_mul (
    .clk  (clk),
    .start(mstart_q),
    .a    (ma_q),
    .b    (mb_q),
    .out  (mul_out),
    .done (mul_done)
  );

  // A done pulse seen in the same cycle as our start belongs to an aborted product.
  assign mul_ack = wait_q & mul_done & ~mstart_q;

`ifdef EC_SPECIAL_CASE_EN
  logic p_inf_s, q_inf_s, same_s;
  assign p_inf_s = (px_q == 256'd0) && (py_q == 256'd0);
  assign q_inf_s = (qx_q == 256'd0) && (qy_q == 256'd0);
  assign same_s  = (px_q == qx_q) && (py_q == qy_q);
`endif

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    num_d    = num_q;
    den_d    = den_q;
    inv_d    = inv_q;
    lam_d    = lam_q;
    x3_d     = x3_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    idx_d    = idx_q;
    dbl_d    = dbl_q;
    wait_d   = wait_q;
    mphase_d = mphase_q;
    done_d   = done_q;
    r_d      = r_q;
    mstart_d = 1'b0;
    if (Reset) begin
      px_d    = P.x;
      py_d    = P.y;
      qx_d    = dbl ? P.x : Q.x;
      qy_d    = dbl ? P.y : Q.y;
      dbl_d   = dbl;
      state_d = S_LOAD;
      r_d     = '0;
      done_d  = 1'b0;
      wait_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d = S_NUM;
`ifdef EC_SPECIAL_CASE_EN
          if (p_inf_s) begin
            if (dbl_q) r_d = '0;
            else r_d = {qx_q, qy_q};
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (!dbl_q && q_inf_s) begin
            r_d     = {px_q, py_q};
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if ((!dbl_q && (px_q == qx_q) && !same_s) ||
                       ((dbl_q || same_s) && (py_q == 256'd0))) begin
            r_d     = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (same_s) begin
            dbl_d = 1'b1;
          end else begin
            dbl_d = dbl_q;
          end
`endif
        end
        S_NUM: begin
          // Add multiplies by one so both modes spend the same cycles here.
          if (!wait_q) begin
            mstart_d = 1'b1;
            wait_d   = 1'b1;
            ma_d     = dbl_q ? px_q : mod_sub(qy_q, py_q);
            mb_d     = dbl_q ? px_q : 256'd1;
          end else if (mul_ack) begin
            wait_d  = 1'b0;
            num_d   = dbl_q ? mod_add(mod_add(mul_out, mul_out), mul_out) : mul_out;
            state_d = S_DEN;
          end else begin
            mstart_d = 1'b0;
          end
        end
        S_DEN: begin
          den_d    = dbl_q ? mod_add(py_q, py_q) : mod_sub(qx_q, px_q);
          inv_d    = 256'd1;
          idx_d    = 8'd255;
          mphase_d = 1'b0;
          state_d  = S_INV;
        end
        S_INV: begin
          if (!wait_q) begin
            mstart_d = 1'b1;
            wait_d   = 1'b1;
            ma_d     = inv_q;
            mb_d     = mphase_q ? den_q : inv_q;
          end else if (mul_ack) begin
            wait_d = 1'b0;
            inv_d  = mul_out;
            if (!mphase_q && P_MINUS_2[idx_q]) begin
              mphase_d = 1'b1;
            end else begin
              mphase_d = 1'b0;
              if (idx_q == 8'd0) state_d = S_LAM;
              else idx_d = idx_q - 8'd1;
            end
          end else begin
            mstart_d = 1'b0;
          end
        end
        S_LAM: begin
          if (!wait_q) begin
            mstart_d = 1'b1;
            wait_d   = 1'b1;
            ma_d     = num_q;
            mb_d     = inv_q;
          end else if (mul_ack) begin
            wait_d  = 1'b0;
            lam_d   = mul_out;
            state_d = S_X3;
          end else begin
            mstart_d = 1'b0;
          end
        end
        S_X3: begin
          if (!wait_q) begin
            mstart_d = 1'b1;
            wait_d   = 1'b1;
            ma_d     = lam_q;
            mb_d     = lam_q;
          end else if (mul_ack) begin
            wait_d  = 1'b0;
            x3_d    = mod_sub(mod_sub(mul_out, px_q), qx_q);
            state_d = S_Y3;
          end else begin
            mstart_d = 1'b0;
          end
        end
        S_Y3: begin
          if (!wait_q) begin
            mstart_d = 1'b1;
            wait_d   = 1'b1;
            ma_d     = lam_q;
            mb_d     = mod_sub(px_q, x3_q);
          end else if (mul_ack) begin
            wait_d  = 1'b0;
            r_d.x   = x3_q;
            r_d.y   = mod_sub(mul_out, py_q);
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            mstart_d = 1'b0;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    px_q     <= px_d;
    py_q     <= py_d;
    qx_q     <= qx_d;
    qy_q     <= qy_d;
    num_q    <= num_d;
    den_q    <= den_d;
    inv_q    <= inv_d;
    lam_q    <= lam_d;
    x3_q     <= x3_d;
    ma_q     <= ma_d;
    mb_q     <= mb_d;
    idx_q    <= idx_d;
    dbl_q    <= dbl_d;
    wait_q   <= wait_d;
    mstart_q <= mstart_d;
    mphase_q <= mphase_d;
    done_q   <= done_d;
    r_q      <= r_d;
  end

  assign R    = r_q;
  assign Done = done_q;

endmodule

// File: tb/tb_ec_point_add_double.sv
// Bench for ec_point_add_double: fixed curve vectors plus a random k1*G + k2*G case
// checked against an affine-arithmetic model built on plain modular arithmetic.
module tb_ec_point_add_double;
  import ec_pkg::*;

  localparam int LAT_MAX = 140000;
  localparam logic [255:0] X2 = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] Y2 = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam logic [255:0] X3 = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
  localparam logic [255:0] Y3 = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;

  typedef struct packed {
    logic         inf;
    logic [255:0] x;
    logic [255:0] y;
  } mpt_t;

  typedef struct {
    string        name;
    logic         d;
    curve_point_t p;
    curve_point_t q;
    curve_point_t e;
  } vec_t;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic         dbl = 1'b0;
  curve_point_t P = '0;
  curve_point_t Q = '0;
  curve_point_t R;
  logic         Done;
  int           checks = 0;
  int           errors = 0;

  ec_point_add_double dut (
    .clk  (clk),
    .Reset(Reset),
    .P    (P),
    .Q    (Q),
    .dbl  (dbl),
    .R    (R),
    .Done (Done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, P_MOD};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = s % {1'b0, P_MOD};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return fadd(a, P_MOD - b);
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] a);
    logic [255:0] r, base, e;
    r = 256'd1; base = a; e = P_MOD - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = fmul(r, base);
      base = fmul(base, base);
    end
    return r;
  endfunction

  function automatic mpt_t m_dbl(input mpt_t a);
    mpt_t r;
    logic [255:0] lam;
    r = '0; r.inf = 1'b1;
    if (!a.inf && a.y != 256'd0) begin
      lam = fmul(fmul(256'd3, fmul(a.x, a.x)), finv(fadd(a.y, a.y)));
      r.inf = 1'b0;
      r.x = fsub(fmul(lam, lam), fadd(a.x, a.x));
      r.y = fsub(fmul(lam, fsub(a.x, r.x)), a.y);
    end
    return r;
  endfunction

  function automatic mpt_t m_add(input mpt_t a, input mpt_t b);
    mpt_t r;
    logic [255:0] lam;
    r = '0; r.inf = 1'b1;
    if (a.inf) r = b;
    else if (b.inf) r = a;
    else if (a.x == b.x) begin
      if (a.y == b.y) r = m_dbl(a);
    end else begin
      lam = fmul(fsub(b.y, a.y), finv(fsub(b.x, a.x)));
      r.inf = 1'b0;
      r.x = fsub(fsub(fmul(lam, lam), a.x), b.x);
      r.y = fsub(fmul(lam, fsub(a.x, r.x)), a.y);
    end
    return r;
  endfunction

  function automatic mpt_t m_smul(input int unsigned k);
    mpt_t r, g;
    r = '0; r.inf = 1'b1;
    g.inf = 1'b0; g.x = GX; g.y = GY;
    for (int i = 31; i >= 0; i--) begin
      r = m_dbl(r);
      if (k[i]) r = m_add(r, g);
    end
    return r;
  endfunction

  task automatic chk_pt(input string nm, input curve_point_t act, input curve_point_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got x=%h y=%h want x=%h y=%h", nm, act.x, act.y, exp.x, exp.y);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s got %0d want <= %0d", nm, act, lim);
    end
  endtask

  // One-cycle Reset with operands, then junk on the inputs while waiting for Done.
  task automatic run_op(input logic d, input curve_point_t a, input curve_point_t b,
                        output curve_point_t res, output int cyc, output int partial);
    @(negedge clk);
    Reset = 1'b1; dbl = d; P = a; Q = b;
    @(negedge clk);
    Reset = 1'b0; dbl = ~d; P = ~a; Q = ~b;
    cyc = 0; partial = 0;
    while (Done !== 1'b1 && cyc <= LAT_MAX) begin
      @(posedge clk); #1;
      cyc++;
      if (Done !== 1'b1 && R !== '0) partial++;
    end
    res = R;
  endtask

  initial begin
    vec_t         vecs[4];
    mpt_t         ma, mb, ms;
    int unsigned  k1, k2;
    curve_point_t g1, g2, g3, res;
    int           cyc, cyc_dbl, part, bad;

    g1 = {GX, GY}; g2 = {X2, Y2}; g3 = {X3, Y3};
    k1 = $urandom_range(3, 40000);
    k2 = k1 + $urandom_range(1, 40000);
    ma = m_smul(k1); mb = m_smul(k2); ms = m_add(ma, mb);

    vecs[0].name = "dbl_G";    vecs[0].d = 1'b1; vecs[0].p = g1;         vecs[0].q = '0;         vecs[0].e = g2;
    vecs[1].name = "add_2G_G"; vecs[1].d = 1'b0; vecs[1].p = g2;         vecs[1].q = g1;         vecs[1].e = g3;
    vecs[2].name = "add_rand"; vecs[2].d = 1'b0; vecs[2].p = {ma.x, ma.y}; vecs[2].q = {mb.x, mb.y}; vecs[2].e = {ms.x, ms.y};
    vecs[3].name = "add_G_2G"; vecs[3].d = 1'b0; vecs[3].p = g1;         vecs[3].q = g2;         vecs[3].e = g3;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_pt("reset_R", R, '0);
      chk_int("reset_Done", int'(Done), 0);
    end

    cyc_dbl = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].d, vecs[i].p, vecs[i].q, res, cyc, part);
      chk_le({vecs[i].name, "_latency"}, cyc, LAT_MAX);
      chk_int({vecs[i].name, "_partial"}, part, 0);
      chk_pt(vecs[i].name, res, vecs[i].e);
      if (i == 0) cyc_dbl = cyc;
      else if (i == 1) chk_int("add_vs_dbl_latency", cyc, cyc_dbl);
    end

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (R !== g3 || Done !== 1'b1) bad++;
    end
    chk_int("hold_100", bad, 0);

    // Abort a doubling 1000 cycles in and restart as an add.
    @(negedge clk);
    Reset = 1'b1; dbl = 1'b1; P = g1; Q = '0;
    @(negedge clk);
    Reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (Done !== 1'b0 || R !== '0) bad++;
    end
    chk_int("midrun_quiet", bad, 0);
    run_op(1'b0, g2, g1, res, cyc, part);
    chk_le("midrun_latency", cyc, LAT_MAX);
    chk_int("midrun_partial", part, 0);
    chk_pt("midrun_3G", res, g3);

`ifdef EC_SPECIAL_CASE_EN
    run_op(1'b0, '0, g1, res, cyc, part);
    chk_le("inf_plus_G_latency", cyc, 4);
    chk_pt("inf_plus_G", res, g1);
    run_op(1'b0, g1, {GX, P_MOD - GY}, res, cyc, part);
    chk_le("G_minus_G_latency", cyc, 4);
    chk_pt("G_minus_G", res, '0);
    run_op(1'b0, g1, g1, res, cyc, part);
    chk_le("G_plus_G_latency", cyc, LAT_MAX);
    chk_pt("G_plus_G", res, g2);
`else
    run_op(1'b0, g1, g1, res, cyc, part);
    chk_le("zero_den_latency", cyc, LAT_MAX);
    chk_int("zero_den_done", int'(Done), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
